synch_delay_gen: RTL

//  Parametrised slave-side synchronisation delay generator. After the link goes idle
//  (Busy falls), it waits (LastSlaveIDPlus1-SlaveID-1)*AveSlaveDelay+TrimOffset+1 cycles,

---
 rtl/synch_delay_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/synch_delay_gen.sv
// rtl/synch_delay_gen.sv - slave-side ring synchronisation delay generator
module synch_delay_gen #(
  parameter int ID_W       = 8,
  parameter int DLY_W      = 8,
  parameter int TRIM_W     = 8,
  parameter int CNT_W      = 32,
  parameter int PULSE_MODE = 0
) (
  input  logic              Clk_100MHz,
  input  logic              Reset,
  input  logic              Busy,
  input  logic [ID_W-1:0]   LastSlaveIDPlus1,
  input  logic [ID_W-1:0]   SlaveID,
  input  logic [DLY_W-1:0]  AveSlaveDelay,
  input  logic [TRIM_W-1:0] TrimOffset,
  output logic              SynchSignal,
  output logic              SynchPulse,
  output logic              Armed,
  output logic              IdError,
  output logic [CNT_W-1:0]  DelayValue
);

  // Wide enough that hops*AveSlaveDelay+TrimOffset+1 can never wrap before saturation.
  localparam int SUM_W = CNT_W + ID_W + DLY_W + TRIM_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_FIRED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   delay_q;
  logic               id_err_q;
  logic               pulse_q;
  logic               enter_fired;

  logic               id_valid;
  logic [ID_W-1:0]    hops;
  logic [SUM_W-1:0]   d_wide;
  logic [CNT_W-1:0]   d_calc;

  // Delay for this slave from current inputs; an invalid ID collapses to zero hops.
  always_comb begin
    id_valid = SlaveID < LastSlaveIDPlus1;
    hops     = id_valid ? (LastSlaveIDPlus1 - SlaveID - ID_W'(1)) : '0;
    d_wide   = SUM_W'(hops) * SUM_W'(AveSlaveDelay) + SUM_W'(TrimOffset) + SUM_W'(1);
    d_calc   = (d_wide > SUM_W'(CNT_MAX)) ? CNT_MAX : d_wide[CNT_W-1:0];
  end

  // Counter increment that sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_nxt = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_W'(1));
  end

  // Delay and ID status follow the inputs while the link is busy, frozen while idle.
  always_ff @(posedge Clk_100MHz) begin
    if (Reset || Busy) begin
      delay_q  <= d_calc;
      id_err_q <= ~id_valid;
    end
  end

  // Next-state logic: count idle edges, fire when the count reaches the latched delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Busy) begin
          cnt_d = '0;
        end else begin
          cnt_d   = cnt_nxt;
          state_d = (cnt_nxt >= delay_q) ? S_FIRED : S_COUNT;
        end
      end
      S_COUNT: begin
        if (Busy) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nxt;
          if (cnt_nxt >= delay_q) begin
            state_d = S_FIRED;
          end
        end
      end
      S_FIRED: begin
        if (Busy) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    enter_fired = (state_d == S_FIRED) && (state_q != S_FIRED);
  end

  // State, counter and one-shot firing strobe registers.
  always_ff @(posedge Clk_100MHz) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= enter_fired;
    end
  end

  assign SynchPulse  = pulse_q;
  assign SynchSignal = (PULSE_MODE != 0) ? pulse_q : (state_q == S_FIRED);
  assign Armed       = (state_q == S_COUNT);
  assign IdError     = id_err_q;
  assign DelayValue  = delay_q;

endmodule
